// File: rtl/hsv_param_ctrl_if.sv
// Handshake and parameter bus between hsv_param_ctrl (master) and the
// HSV->RGB converter (slave). The master presents hue/sat/val together with
// conv_start; the converter accepts with conv_ready and signals completion
// with a one-cycle conv_done pulse.
interface hsv_param_ctrl_if;
  logic       conv_start;
  logic       conv_ready;
  logic       conv_done;
  logic [8:0] hue;
  logic [6:0] sat;
  logic [6:0] val;

  modport master (
    output conv_start, hue, sat, val,
    input  conv_ready, conv_done
  );

  modport slave (
    input  conv_start, hue, sat, val,
    output conv_ready, conv_done
  );
endinterface

// File: rtl/hsv_param_ctrl.sv
// HSV parameter sequencer for the LED colour pipeline.
// Updates hue/sat/val according to the selected mode on every mode change
// (entry) and on every step tick, then hands the new triple to the HSV->RGB
// converter through a start/ready/done handshake with a done timeout.
// Optional build macro HSV_CTRL_FADE_EN: modes 4/5/6 move sat/val by one
// step per event toward their target instead of jumping to it.
//
// state  | meaning
// IDLE   | waiting for a pending event
// APPLY  | one cycle, mode action updates hue/sat/val, pending cleared
// LAUNCH | conv_start held high until the converter accepts
// WAIT   | waiting for conv_done, bounded by TIMEOUT_CYCLES
module hsv_param_ctrl #(
  parameter int STEP_CYCLES    = 10000000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [3:0]       i_sost,
  input  logic [8:0]       i_h_in,
  input  logic [6:0]       i_s_in,
  input  logic [6:0]       i_v_in,
  hsv_param_ctrl_if.master io_conv,
  output logic             o_busy,
  output logic             o_err
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_LAUNCH, S_WAIT} state_t;

  state_t          r_state;
  logic [3:0]      r_sost_q;
  logic [TW-1:0]   r_tick_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_pending;
  logic [8:0]      r_hue;
  logic [6:0]      r_sat;
  logic [6:0]      r_val;
  logic            r_start;
  logic            r_busy;
  logic            r_err;

  logic            w_entry;
  logic            w_tick;
  logic            w_event;
  logic [9:0]      w_hue_p60;
  logic [9:0]      w_hue_p1;
  logic [8:0]      w_h_tgt;
  logic [6:0]      w_s_tgt;
  logic [6:0]      w_v_tgt;
  logic [8:0]      w_hue_nxt;
  logic [6:0]      w_sat_nxt;
  logic [6:0]      w_val_nxt;

`ifdef HSV_CTRL_FADE_EN
  function automatic logic [6:0] f_toward(input logic [6:0] cur, input logic [6:0] tgt);
    if (cur < tgt)      return cur + 7'd1;
    else if (cur > tgt) return cur - 7'd1;
    else                return cur;
  endfunction
`endif

  assign w_entry   = (i_sost != r_sost_q);
  assign w_tick    = (r_tick_cnt == TICK_LAST);
  assign w_event   = w_entry | w_tick;

  // Hue arithmetic is done one bit wider so the wrap past 359 is visible.
  assign w_hue_p60 = {1'b0, r_hue} + 10'd60;
  assign w_hue_p1  = {1'b0, r_hue} + 10'd1;
  assign w_h_tgt   = (i_h_in > 9'd359) ? 9'd359 : i_h_in;
  assign w_s_tgt   = (i_s_in > 7'd100) ? 7'd100 : i_s_in;
  assign w_v_tgt   = (i_v_in > 7'd100) ? 7'd100 : i_v_in;

  // Next hue/sat/val for the mode latched in r_sost_q; only committed in APPLY.
  always_comb begin
    w_hue_nxt = r_hue;
    w_sat_nxt = r_sat;
    w_val_nxt = r_val;
    case (r_sost_q)
      4'd0: w_hue_nxt = 9'd120;
      4'd1: w_hue_nxt = (w_hue_p60 >= 10'd360) ? 9'(w_hue_p60 - 10'd360) : w_hue_p60[8:0];
      4'd2: w_hue_nxt = (w_hue_p1 >= 10'd360) ? 9'd0 : w_hue_p1[8:0];
      4'd3: w_hue_nxt = w_h_tgt;
`ifdef HSV_CTRL_FADE_EN
      4'd4: w_val_nxt = f_toward(r_val, w_v_tgt);
      4'd5: w_sat_nxt = f_toward(r_sat, w_s_tgt);
      4'd6: begin
        w_sat_nxt = f_toward(r_sat, 7'd50);
        w_val_nxt = f_toward(r_val, 7'd50);
      end
`else
      4'd4: w_val_nxt = w_v_tgt;
      4'd5: w_sat_nxt = w_s_tgt;
      4'd6: begin
        w_sat_nxt = 7'd50;
        w_val_nxt = 7'd50;
      end
`endif
      default: ;
    endcase
  end

  // Step tick counter and mode history; a mode change restarts the step period.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sost_q   <= i_sost;
      r_tick_cnt <= '0;
    end else begin
      r_sost_q <= i_sost;
      if (w_entry || w_tick) r_tick_cnt <= '0;
      else                   r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Sequencing FSM with registered handshake outputs and parameter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_pending  <= 1'b0;
      r_wait_cnt <= '0;
      r_hue      <= 9'd120;
      r_sat      <= 7'd100;
      r_val      <= 7'd100;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_state <= S_APPLY;
            r_busy  <= 1'b1;
          end
        end
        S_APPLY: begin
          r_hue     <= w_hue_nxt;
          r_sat     <= w_sat_nxt;
          r_val     <= w_val_nxt;
          r_pending <= 1'b0;
          r_start   <= 1'b1;
          r_state   <= S_LAUNCH;
        end
        S_LAUNCH: begin
          if (io_conv.conv_ready) begin
            r_start    <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (io_conv.conv_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
      // An event in the APPLY cycle itself must not be lost, so it wins over the clear.
      if (w_event) r_pending <= 1'b1;
    end
  end

  assign io_conv.conv_start = r_start;
  assign io_conv.hue        = r_hue;
  assign io_conv.sat        = r_sat;
  assign io_conv.val        = r_val;
  assign o_busy             = r_busy;
  assign o_err              = r_err;

endmodule
